// File: rtl/mel_frame_sequencer_if.sv
// Handshake bundle between the MEL frame sequencer and its neighbours:
// power-spectrum producer, MEL filterbank engine and DCT stage.
interface mel_frame_sequencer_if #(
    parameter int ENERGY_W = 9
);
    logic                ps_frame_ready_i;
    logic                ps_wr_bank_o;
    logic                ps_rd_bank_o;
    logic                mel_start_o;
    logic                mel_valid_i;
    logic [5:0]          mel_idx_i;
    logic [ENERGY_W-1:0] mel_value_i;
    logic                mel_done_i;
    logic                dct_start_o;
    logic [5:0]          dct_rd_addr_i;
    logic [ENERGY_W-1:0] dct_rd_data_o;
    logic                dct_done_i;

    // Environment side: producer, MEL engine and DCT stage.
    modport master (
        output ps_frame_ready_i, mel_valid_i, mel_idx_i, mel_value_i, mel_done_i,
               dct_rd_addr_i, dct_done_i,
        input  ps_wr_bank_o, ps_rd_bank_o, mel_start_o, dct_start_o, dct_rd_data_o
    );

    // Sequencer side.
    modport slave (
        input  ps_frame_ready_i, mel_valid_i, mel_idx_i, mel_value_i, mel_done_i,
               dct_rd_addr_i, dct_done_i,
        output ps_wr_bank_o, ps_rd_bank_o, mel_start_o, dct_start_o, dct_rd_data_o
    );
endinterface

// File: rtl/mel_frame_sequencer.sv
// Frame-level controller for the MEL stage: ping-pong bank ownership, MEL/DCT
// start sequencing and a local register file of per-filter log-energies.
module mel_frame_sequencer #(
    parameter int NUM_FILTERS = 40,
    parameter int ENERGY_W    = 9,
    parameter int FCNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    mel_frame_sequencer_if.slave bus,
    output logic                 busy_o,
    output logic [FCNT_W-1:0]    frame_count_o,
    output logic                 overrun_o,
    output logic                 filt_err_o
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MEL_RUN   = 2'd1;
    localparam logic [1:0] S_DCT_START = 2'd2;
    localparam logic [1:0] S_DCT_RUN   = 2'd3;

    localparam int CNT_W = 8;
    localparam logic [6:0]       NF_7     = 7'(NUM_FILTERS);
    localparam logic [CNT_W-1:0] NF_COUNT = CNT_W'(NUM_FILTERS);

    logic [1:0]          state;
    logic [1:0]          full_cnt;
    logic                wr_bank;
    logic                rd_bank;
    logic [CNT_W-1:0]    valid_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [ENERGY_W-1:0] energy [NUM_FILTERS];

    logic idx_ok;
    logic strobe_ok;
    logic strobe_bad;
    logic bank_release;
    logic accept;
    logic drop;
    logic mel_start;

    assign idx_ok       = ({1'b0, bus.mel_idx_i} < NF_7);
    assign strobe_ok    = (state == S_MEL_RUN) && bus.mel_valid_i && idx_ok;
    assign strobe_bad   = (state == S_MEL_RUN) && bus.mel_valid_i && !idx_ok;
    assign bank_release = (state == S_MEL_RUN) && bus.mel_done_i;
    // A release in the same cycle frees a slot, so a ready pulse on a full pair is still taken.
    assign accept       = bus.ps_frame_ready_i && ((full_cnt != 2'd2) || bank_release);
    assign drop         = bus.ps_frame_ready_i && !accept;
    assign mel_start    = (state == S_IDLE) && enable_i && (full_cnt != 2'd0);

    // Saturating strobe count so a runaway MEL engine cannot wrap back to a "good" total.
    always_comb begin
        cnt_next = valid_cnt;
        if (strobe_ok && (valid_cnt != '1)) cnt_next = valid_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_cnt  <= 2'd0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            full_cnt <= full_cnt + 2'(accept) - 2'(bank_release);
            if (accept)       wr_bank   <= ~wr_bank;
            if (bank_release) rd_bank   <= ~rd_bank;
            if (drop)         overrun_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            valid_cnt     <= '0;
            filt_err_o    <= 1'b0;
            frame_count_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mel_start) begin
                        valid_cnt <= '0;
                        state     <= S_MEL_RUN;
                    end
                end
                S_MEL_RUN: begin
                    valid_cnt <= cnt_next;
                    if (strobe_bad) filt_err_o <= 1'b1;
                    if (bus.mel_done_i) begin
                        if (cnt_next != NF_COUNT) filt_err_o <= 1'b1;
                        state <= S_DCT_START;
                    end
                end
                S_DCT_START: state <= S_DCT_RUN;
                S_DCT_RUN: begin
                    if (bus.dct_done_i) begin
                        frame_count_o <= frame_count_o + 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the energy file is reset explicitly so an aborted frame never leaks stale energies to DCT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FILTERS; i++) energy[i] <= '0;
        end else if (strobe_ok) begin
            energy[bus.mel_idx_i] <= bus.mel_value_i;
        end
    end

    assign bus.dct_rd_data_o = ({1'b0, bus.dct_rd_addr_i} < NF_7) ? energy[bus.dct_rd_addr_i] : '0;
    assign bus.ps_wr_bank_o  = wr_bank;
    assign bus.ps_rd_bank_o  = rd_bank;
    assign bus.mel_start_o   = mel_start;
    assign bus.dct_start_o   = (state == S_DCT_START);
    assign busy_o            = (state != S_IDLE);

endmodule

// File: tb/tb_mel_frame_sequencer.sv
// Directed bench for mel_frame_sequencer: bank ping-pong, overrun, filter
// count/index errors, enable gating and mid-frame reset.
module tb_mel_frame_sequencer;
    localparam int NF = 40;
    localparam int EW = 9;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          busy;
    logic [FW-1:0] frame_count;
    logic          overrun;
    logic          filt_err;

    int n_checks = 0;
    int n_pass   = 0;
    int mel_starts = 0;
    int dct_starts = 0;
    int s0;
    int d0;

    mel_frame_sequencer_if #(.ENERGY_W(EW)) bus ();

    mel_frame_sequencer #(.NUM_FILTERS(NF), .ENERGY_W(EW), .FCNT_W(FW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .bus           (bus),
        .busy_o        (busy),
        .frame_count_o (frame_count),
        .overrun_o     (overrun),
        .filt_err_o    (filt_err)
    );

    always #5 clk = ~clk;

    // Start pulses last one full cycle, so counting on the falling edge sees each exactly once.
    always @(negedge clk) begin
        if (bus.mel_start_o) mel_starts++;
        if (bus.dct_start_o) dct_starts++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.ps_frame_ready_i = 1'b0;
        bus.mel_valid_i      = 1'b0;
        bus.mel_idx_i        = '0;
        bus.mel_value_i      = '0;
        bus.mel_done_i       = 1'b0;
        bus.dct_rd_addr_i    = '0;
        bus.dct_done_i       = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_ready();
        bus.ps_frame_ready_i = 1'b1;
        tick();
        bus.ps_frame_ready_i = 1'b0;
    endtask

    // Called one cycle into MEL_RUN; returns in the DCT_START cycle.
    task automatic mel_frame(input int n, input bit bad, input bit ready_on_done);
        if (bad) begin
            bus.mel_valid_i = 1'b1;
            bus.mel_idx_i   = 6'd45;
            bus.mel_value_i = 9'd7;
            tick();
        end
        for (int i = 0; i < n; i++) begin
            bus.mel_valid_i = 1'b1;
            bus.mel_idx_i   = 6'(i);
            bus.mel_value_i = 9'(i);
            tick();
        end
        bus.mel_valid_i      = 1'b0;
        bus.mel_done_i       = 1'b1;
        bus.ps_frame_ready_i = ready_on_done;
        tick();
        bus.mel_done_i       = 1'b0;
        bus.ps_frame_ready_i = 1'b0;
    endtask

    // Called in the DCT_START cycle; returns in the first IDLE cycle.
    task automatic finish_dct(input int delay);
        tick();
        repeat (delay) tick();
        bus.dct_done_i = 1'b1;
        tick();
        bus.dct_done_i = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int addr, input int exp);
        bus.dct_rd_addr_i = 6'(addr);
        #1;
        check(tag, 32'(bus.dct_rd_data_o), 32'(exp));
    endtask

    initial begin
        // 1: single clean frame
        enable = 1'b1;
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_bank", 32'(bus.ps_wr_bank_o), 0);
        check("rst_rd_bank", 32'(bus.ps_rd_bank_o), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_flags", {30'd0, overrun, filt_err}, 0);
        check("rst_mel_start", 32'(bus.mel_start_o), 0);
        rd_check("rst_energy39", 39, 0);
        s0 = mel_starts;
        d0 = dct_starts;
        pulse_ready();
        check("t1_start_latency", 32'(bus.mel_start_o), 1);
        check("t1_wr_bank", 32'(bus.ps_wr_bank_o), 1);
        tick();
        check("t1_busy", 32'(busy), 1);
        mel_frame(NF, 1'b0, 1'b0);
        check("t1_dct_start", 32'(bus.dct_start_o), 1);
        check("t1_rd_bank", 32'(bus.ps_rd_bank_o), 1);
        check("t1_filt_err", 32'(filt_err), 0);
        tick();
        bus.mel_valid_i = 1'b1;
        bus.mel_idx_i   = 6'd5;
        bus.mel_value_i = 9'd100;
        tick();
        bus.mel_valid_i = 1'b0;
        repeat (8) tick();
        bus.dct_done_i = 1'b1;
        tick();
        bus.dct_done_i = 1'b0;
        repeat (3) tick();
        check("t1_frame_count", 32'(frame_count), 1);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_mel_starts", 32'(mel_starts - s0), 1);
        check("t1_dct_starts", 32'(dct_starts - d0), 1);
        rd_check("t1_energy39", 39, 39);
        rd_check("t1_energy20", 20, 20);
        rd_check("t1_frozen5", 5, 5);

        // 2: overrun while MEL stalled, then two frames
        do_reset();
        s0 = mel_starts;
        pulse_ready();
        tick();
        pulse_ready();
        check("t2_wr_second", 32'(bus.ps_wr_bank_o), 0);
        check("t2_no_overrun_yet", 32'(overrun), 0);
        pulse_ready();
        check("t2_overrun", 32'(overrun), 1);
        check("t2_wr_after_drop", 32'(bus.ps_wr_bank_o), 0);
        mel_frame(NF, 1'b0, 1'b0);
        finish_dct(2);
        check("t2_restart", 32'(bus.mel_start_o), 1);
        tick();
        mel_frame(NF, 1'b0, 1'b0);
        finish_dct(2);
        tick();
        check("t2_frame_count", 32'(frame_count), 2);
        check("t2_rd_bank", 32'(bus.ps_rd_bank_o), 0);
        check("t2_mel_starts", 32'(mel_starts - s0), 2);
        check("t2_idle", 32'(busy), 0);

        // 3: ready coincident with release on a full pair
        do_reset();
        pulse_ready();
        tick();
        pulse_ready();
        mel_frame(NF, 1'b0, 1'b1);
        check("t3_no_overrun", 32'(overrun), 0);
        check("t3_wr_bank", 32'(bus.ps_wr_bank_o), 1);
        check("t3_rd_bank", 32'(bus.ps_rd_bank_o), 1);
        finish_dct(1);
        check("t3_restart", 32'(bus.mel_start_o), 1);
        pulse_ready();
        check("t3_full_still_2", 32'(overrun), 1);

        // 4a: short frame
        do_reset();
        pulse_ready();
        tick();
        mel_frame(NF - 1, 1'b0, 1'b0);
        check("t4_short_err", 32'(filt_err), 1);
        check("t4_short_dct", 32'(bus.dct_start_o), 1);
        finish_dct(1);
        check("t4_short_count", 32'(frame_count), 1);

        // 4b: out-of-range index
        do_reset();
        pulse_ready();
        tick();
        mel_frame(NF, 1'b1, 1'b0);
        check("t4_idx_err", 32'(filt_err), 1);
        check("t4_idx_dct", 32'(bus.dct_start_o), 1);
        rd_check("t4_addr45", 45, 0);
        rd_check("t4_addr39", 39, 39);
        finish_dct(1);

        // 5: enable gating
        enable = 1'b0;
        do_reset();
        pulse_ready();
        repeat (3) tick();
        check("t5_held", 32'(bus.mel_start_o), 0);
        check("t5_idle", 32'(busy), 0);
        s0 = mel_starts;
        enable = 1'b1;
        #1;
        check("t5_start_on_enable", 32'(bus.mel_start_o), 1);
        tick();
        enable = 1'b0;
        check("t5_busy", 32'(busy), 1);
        mel_frame(NF, 1'b0, 1'b0);
        finish_dct(3);
        tick();
        check("t5_frame_count", 32'(frame_count), 1);
        check("t5_mel_starts", 32'(mel_starts - s0), 1);

        // 6: reset during MEL_RUN
        enable = 1'b1;
        do_reset();
        pulse_ready();
        tick();
        pulse_ready();
        for (int i = 0; i < 5; i++) begin
            bus.mel_valid_i = 1'b1;
            bus.mel_idx_i   = 6'(i);
            bus.mel_value_i = 9'(i + 1);
            tick();
        end
        bus.mel_valid_i   = 1'b0;
        bus.dct_rd_addr_i = 6'd3;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_banks", {30'd0, bus.ps_wr_bank_o, bus.ps_rd_bank_o}, 0);
        check("t6_energy3", 32'(bus.dct_rd_data_o), 0);
        tick();
        rst_n = 1'b1;
        s0 = mel_starts;
        repeat (5) tick();
        check("t6_no_start", 32'(mel_starts - s0), 0);
        check("t6_still_idle", 32'(busy), 0);
        pulse_ready();
        check("t6_new_ready", 32'(bus.mel_start_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
